// File: rtl/nw_topic_counter_if.sv
// rtl/nw_topic_counter_if.sv - command/result bundle for nw_topic_counter
interface nw_topic_counter_if #(
    parameter int WORDSIZE = 32,
    parameter int ADDRSIZE = 10
);
    logic                i_valid;
    logic [1:0]          i_op;
    logic [ADDRSIZE-1:0] i_addr;
    logic [WORDSIZE-1:0] i_wdata;
    logic                o_ready;
    logic                o_rvalid;
    logic [WORDSIZE-1:0] o_rdata;
    logic                o_sat;

    modport master (
        output i_valid, i_op, i_addr, i_wdata,
        input  o_ready, o_rvalid, o_rdata, o_sat
    );

    modport slave (
        input  i_valid, i_op, i_addr, i_wdata,
        output o_ready, o_rvalid, o_rdata, o_sat
    );
endinterface

// File: rtl/nw_topic_counter.sv
// rtl/nw_topic_counter.sv - word-topic count RAM with atomic RMW, saturation and clear sweep
module nw_topic_counter #(
    parameter int WORDSIZE = 32,
    parameter int ADDRSIZE = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    nw_topic_counter_if.slave bus
);
    localparam int         DEPTH    = 2**ADDRSIZE;
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_DEC   = 2'b11;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDRSIZE-1:0] r_clr_cnt;
    logic                w_ready, w_clr_we, w_accept;

    logic [WORDSIZE-1:0] r_mem [DEPTH];
    logic [WORDSIZE-1:0] r_ram_q;

    logic                r_b_valid, r_b_fwd;
    logic [1:0]          r_b_op;
    logic [ADDRSIZE-1:0] r_b_addr;
    logic [WORDSIZE-1:0] r_b_wdata;
    logic [WORDSIZE-1:0] w_operand, w_new;
    logic                w_sat, w_b_we;

    logic                r_rvalid, r_sat;
    logic [WORDSIZE-1:0] r_rdata;

    logic                w_we;
    logic [ADDRSIZE-1:0] w_waddr;
    logic [WORDSIZE-1:0] w_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_clr_cnt == '1) w_state_nxt = ST_RUN;
    end

    always_comb begin
        w_ready  = (r_state == ST_RUN);
        w_clr_we = (r_state == ST_INIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_clr_cnt <= '0;
        else if (w_clr_we) r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    assign w_accept = bus.i_valid && w_ready;

    // Read-first: a same-cycle write to the read address returns the old word.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
        r_ram_q <= r_mem[bus.i_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_valid <= 1'b0;
            r_b_fwd   <= 1'b0;
            r_b_op    <= OP_READ;
            r_b_addr  <= '0;
            r_b_wdata <= '0;
        end else begin
            r_b_valid <= w_accept;
            if (w_accept) begin
                r_b_op    <= bus.i_op;
                r_b_addr  <= bus.i_addr;
                r_b_wdata <= bus.i_wdata;
                r_b_fwd   <= w_b_we && (r_b_addr == bus.i_addr);
            end
        end
    end

    // A distance-1 hit takes its operand from the result register, which holds the word just written.
    always_comb begin
        w_operand = r_b_fwd ? r_rdata : r_ram_q;
        w_new     = w_operand;
        w_sat     = 1'b0;
        case (r_b_op)
            OP_WRITE: w_new = r_b_wdata;
            OP_INC: begin
                if (w_operand == '1) w_sat = 1'b1;
                else                 w_new = w_operand + 1'b1;
            end
            OP_DEC: begin
                if (w_operand == '0) w_sat = 1'b1;
                else                 w_new = w_operand - 1'b1;
            end
            default: ;
        endcase
    end

    assign w_b_we = r_b_valid && (r_b_op != OP_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_sat    <= 1'b0;
        end else begin
            r_rvalid <= r_b_valid;
            if (r_b_valid) begin
                r_rdata <= w_new;
                r_sat   <= w_sat;
            end
        end
    end

    assign w_we    = w_clr_we || w_b_we;
    assign w_waddr = w_clr_we ? r_clr_cnt : r_b_addr;
    assign w_wdata = w_clr_we ? '0 : w_new;

    assign bus.o_ready  = w_ready;
    assign bus.o_rvalid = r_rvalid;
    assign bus.o_rdata  = r_rdata;
    assign bus.o_sat    = r_sat;
endmodule
